// File: rtl/ahb_lite_cmd_master.sv
// ahb_lite_cmd_master
// AHB-Lite initiator: queued commands become single-beat word transfers.
// The address phase of one transfer overlaps the data phase of the previous
// one; completed transfers are returned through a response queue.
//
// Handshake semantics (both queues): a transfer happens on a rising HCLK
// edge where valid && ready are both 1. The producer holds valid and its
// payload stable until that edge; ready never depends combinationally on
// valid. Here cmd_ready and rsp_valid are driven from registered counts only.
module ahb_lite_cmd_master #(
  parameter int W_ADDR    = 32,
  parameter int W_DATA    = 32,
  parameter int CMD_DEPTH = 4,
  parameter int RSP_DEPTH = 4
) (
  input  logic              HCLK,
  input  logic              HRESET,
  // command queue
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [W_ADDR-1:0] cmd_addr,
  input  logic [W_DATA-1:0] cmd_wdata,
  // response queue
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_write,
  output logic              rsp_err,
  output logic [W_DATA-1:0] rsp_rdata,
  // AHB-Lite master port
  output logic [W_ADDR-1:0] o_HADDR,
  output logic              o_HWRITE,
  output logic [2:0]        o_HSIZE,
  output logic [2:0]        o_HBURST,
  output logic [1:0]        o_HTRANS,
  output logic [W_DATA-1:0] o_HWDATA,
  input  logic [W_DATA-1:0] i_HRDATA,
  input  logic              i_HREADY,
  input  logic [1:0]        i_HRESP,
  // status
  output logic              busy
);

  localparam int CPW = $clog2(CMD_DEPTH);
  localparam int CCW = CPW + 1;
  localparam int RPW = $clog2(RSP_DEPTH);
  localparam int RCW = RPW + 1;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HRESP_ERROR   = 2'b01;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  localparam logic [CCW-1:0] CMD_FULL_COUNT = CCW'(CMD_DEPTH);
  localparam logic [RCW-1:0] RSP_CREDITS    = RCW'(RSP_DEPTH);

  // ---------------------------------------------------------------------
  // Command FIFO state
  // ---------------------------------------------------------------------
  logic              r_cmd_write_mem [CMD_DEPTH];
  logic [W_ADDR-1:0] r_cmd_addr_mem  [CMD_DEPTH];
  logic [W_DATA-1:0] r_cmd_wdata_mem [CMD_DEPTH];
  logic [CPW-1:0]    r_cmd_wptr;
  logic [CPW-1:0]    r_cmd_rptr;
  logic [CCW-1:0]    r_cmd_count;

  // ---------------------------------------------------------------------
  // Response FIFO state
  // ---------------------------------------------------------------------
  logic              r_rsp_write_mem [RSP_DEPTH];
  logic              r_rsp_err_mem   [RSP_DEPTH];
  logic [W_DATA-1:0] r_rsp_rdata_mem [RSP_DEPTH];
  logic [RPW-1:0]    r_rsp_wptr;
  logic [RPW-1:0]    r_rsp_rptr;
  logic [RCW-1:0]    r_rsp_count;

  // ---------------------------------------------------------------------
  // Data-phase stage and error flag
  // ---------------------------------------------------------------------
  logic              r_d_vld;
  logic              r_d_write;
  logic [W_DATA-1:0] r_d_wdata;
  logic              r_err_q;

  // ---------------------------------------------------------------------
  // Control wires
  // ---------------------------------------------------------------------
  logic              w_cmd_empty;
  logic              w_cmd_full;
  logic              w_cmd_push;
  logic              w_cmd_pop;
  logic              w_head_write;
  logic [W_ADDR-1:0] w_head_addr;
  logic [W_DATA-1:0] w_head_wdata;
  logic [RCW-1:0]    w_rsp_used;
  logic              w_issue;
  logic              w_addr_accept;
  logic              w_data_done;
  logic              w_resp_is_err;
  logic              w_err_first;
  logic              w_rsp_push;
  logic              w_rsp_pop;
  logic [W_DATA-1:0] w_rsp_push_rdata;

  assign w_cmd_empty  = (r_cmd_count == '0);
  assign w_cmd_full   = (r_cmd_count == CMD_FULL_COUNT);
  assign w_head_write = r_cmd_write_mem[r_cmd_rptr];
  assign w_head_addr  = r_cmd_addr_mem[r_cmd_rptr];
  assign w_head_wdata = r_cmd_wdata_mem[r_cmd_rptr];

  // A response slot is reserved for the transfer already in its data phase,
  // so the response FIFO can never be pushed while full.
  assign w_rsp_used = r_rsp_count + {{(RCW-1){1'b0}}, r_d_vld};

  // Issue is purely a function of registered state so the address phase
  // never depends on same-cycle slave inputs.
  assign w_issue       = !w_cmd_empty && !r_err_q && (w_rsp_used < RSP_CREDITS);
  assign w_addr_accept = w_issue && i_HREADY;
  assign w_data_done   = r_d_vld && i_HREADY;
  assign w_resp_is_err = (i_HRESP == HRESP_ERROR);
  // First cycle of the two-cycle ERROR response.
  assign w_err_first   = r_d_vld && !i_HREADY && w_resp_is_err;

  assign w_cmd_push       = cmd_valid && !w_cmd_full;
  assign w_cmd_pop        = w_addr_accept;
  assign w_rsp_push       = w_data_done;
  assign w_rsp_pop        = rsp_valid && rsp_ready;
  assign w_rsp_push_rdata = r_d_write ? '0 : i_HRDATA;

  // ---------------------------------------------------------------------
  // Command FIFO
  // ---------------------------------------------------------------------

  // Command payload storage; contents are don't-care while the slot is free.
  always_ff @(posedge HCLK) begin
    if (w_cmd_push) begin
      r_cmd_write_mem[r_cmd_wptr] <= cmd_write;
      r_cmd_addr_mem[r_cmd_wptr]  <= cmd_addr;
      r_cmd_wdata_mem[r_cmd_wptr] <= cmd_wdata;
    end
  end

  // Command pointers and occupancy count.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_cmd_wptr  <= '0;
      r_cmd_rptr  <= '0;
      r_cmd_count <= '0;
    end else begin
      if (w_cmd_push) r_cmd_wptr <= r_cmd_wptr + 1'b1;
      if (w_cmd_pop)  r_cmd_rptr <= r_cmd_rptr + 1'b1;
      case ({w_cmd_push, w_cmd_pop})
        2'b10:   r_cmd_count <= r_cmd_count + 1'b1;
        2'b01:   r_cmd_count <= r_cmd_count - 1'b1;
        default: r_cmd_count <= r_cmd_count;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Data-phase stage
  // ---------------------------------------------------------------------

  // Capture the accepted head into the data stage; hold through wait states.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_d_vld   <= 1'b0;
      r_d_write <= 1'b0;
      r_d_wdata <= '0;
    end else if (w_addr_accept) begin
      r_d_vld   <= 1'b1;
      r_d_write <= w_head_write;
      r_d_wdata <= w_head_wdata;
    end else if (i_HREADY) begin
      r_d_vld   <= 1'b0;
    end
  end

  // Error flag: set in the first ERROR cycle, cleared by the completing edge.
  // While set, the next address phase is suppressed so the head is reissued.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_err_q <= 1'b0;
    end else if (i_HREADY) begin
      r_err_q <= 1'b0;
    end else if (w_err_first) begin
      r_err_q <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Response FIFO
  // ---------------------------------------------------------------------

  // Response payload storage written at data-phase completion.
  always_ff @(posedge HCLK) begin
    if (w_rsp_push) begin
      r_rsp_write_mem[r_rsp_wptr] <= r_d_write;
      r_rsp_err_mem[r_rsp_wptr]   <= w_resp_is_err;
      r_rsp_rdata_mem[r_rsp_wptr] <= w_rsp_push_rdata;
    end
  end

  // Response pointers and occupancy count.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_rsp_wptr  <= '0;
      r_rsp_rptr  <= '0;
      r_rsp_count <= '0;
    end else begin
      if (w_rsp_push) r_rsp_wptr <= r_rsp_wptr + 1'b1;
      if (w_rsp_pop)  r_rsp_rptr <= r_rsp_rptr + 1'b1;
      case ({w_rsp_push, w_rsp_pop})
        2'b10:   r_rsp_count <= r_rsp_count + 1'b1;
        2'b01:   r_rsp_count <= r_rsp_count - 1'b1;
        default: r_rsp_count <= r_rsp_count;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------

  // Address phase: present the FIFO head only while issuing, else park IDLE.
  always_comb begin
    o_HTRANS = HTRANS_IDLE;
    o_HADDR  = '0;
    o_HWRITE = 1'b0;
    if (w_issue) begin
      o_HTRANS = HTRANS_NONSEQ;
      o_HADDR  = w_head_addr;
      o_HWRITE = w_head_write;
    end
  end

  // Data phase, fixed transfer attributes, queue status and busy.
  always_comb begin
    o_HWDATA  = r_d_vld ? r_d_wdata : '0;
    o_HSIZE   = HSIZE_WORD;
    o_HBURST  = HBURST_SINGLE;
    cmd_ready = !w_cmd_full;
    rsp_valid = (r_rsp_count != '0);
    rsp_write = r_rsp_write_mem[r_rsp_rptr];
    rsp_err   = r_rsp_err_mem[r_rsp_rptr];
    rsp_rdata = r_rsp_rdata_mem[r_rsp_rptr];
    busy      = !w_cmd_empty || r_d_vld || r_err_q;
  end

endmodule

// File: tb/tb_ahb_lite_cmd_master.sv
// Bench for ahb_lite_cmd_master: directed scenarios with literal expectations
// followed by randomized traffic checked every cycle against a queue model.
module tb_ahb_lite_cmd_master;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int CD = 4;
  localparam int RD = 4;

  // ---------------- clock / reset ----------------
  logic          HCLK;
  logic          HRESET;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid, rsp_ready, rsp_write, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] o_HADDR;
  logic          o_HWRITE;
  logic [2:0]    o_HSIZE, o_HBURST;
  logic [1:0]    o_HTRANS;
  logic [DW-1:0] o_HWDATA;
  logic [DW-1:0] i_HRDATA;
  logic          i_HREADY;
  logic [1:0]    i_HRESP;
  logic          busy;

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  ahb_lite_cmd_master #(
    .W_ADDR(AW), .W_DATA(DW), .CMD_DEPTH(CD), .RSP_DEPTH(RD)
  ) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .o_HADDR(o_HADDR), .o_HWRITE(o_HWRITE), .o_HSIZE(o_HSIZE),
    .o_HBURST(o_HBURST), .o_HTRANS(o_HTRANS), .o_HWDATA(o_HWDATA),
    .i_HRDATA(i_HRDATA), .i_HREADY(i_HREADY), .i_HRESP(i_HRESP),
    .busy(busy)
  );

  // ---------------- scoreboard / model ----------------
  typedef struct packed {
    logic          w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } cmd_t;

  cmd_t          m_cmd_q[$];      // commands waiting for address acceptance
  logic [DW+1:0] exp_q[$];        // expected responses {write, err, rdata}
  logic          m_d_vld;
  logic          m_d_write;
  logic [DW-1:0] m_d_wdata;
  logic          m_err;
  logic          last_cmd_acc;
  logic          slv_err2;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_issue();
    return (m_cmd_q.size() != 0) && !m_err &&
           ((exp_q.size() + (m_d_vld ? 1 : 0)) < RD);
  endfunction

  task automatic model_reset();
    m_cmd_q.delete();
    exp_q.delete();
    m_d_vld      = 1'b0;
    m_d_write    = 1'b0;
    m_d_wdata    = '0;
    m_err        = 1'b0;
    last_cmd_acc = 1'b0;
    slv_err2     = 1'b0;
  endtask

  // Expected outputs follow from the queue contents alone.
  task automatic compare_outputs();
    bit            iss;
    logic [AW-1:0] ea;
    logic          ew;
    logic [DW+1:0] r;
    iss = m_issue();
    ea  = '0;
    ew  = 1'b0;
    if (iss) begin
      ea = m_cmd_q[0].a;
      ew = m_cmd_q[0].w;
    end
    check("htrans", 64'(o_HTRANS), iss ? 64'd2 : 64'd0);
    check("haddr", 64'(o_HADDR), 64'(ea));
    check("hwrite", 64'(o_HWRITE), 64'(ew));
    check("hwdata", 64'(o_HWDATA), m_d_vld ? 64'(m_d_wdata) : 64'd0);
    check("hsize", 64'(o_HSIZE), 64'd2);
    check("hburst", 64'(o_HBURST), 64'd0);
    check("cmd_ready", 64'(cmd_ready), 64'(m_cmd_q.size() < CD));
    check("rsp_valid", 64'(rsp_valid), 64'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      r = exp_q[0];
      check("rsp_write", 64'(rsp_write), 64'(r[DW+1]));
      check("rsp_err", 64'(rsp_err), 64'(r[DW]));
      check("rsp_rdata", 64'(rsp_rdata), 64'(r[DW-1:0]));
    end
    check("busy", 64'(busy), 64'(m_cmd_q.size() != 0 || m_d_vld || m_err));
  endtask

  // Advance the model by one clock edge using the inputs presented this cycle.
  task automatic model_update();
    bit            iss, acc_addr, push_rsp, pop_rsp, acc_cmd;
    logic [DW+1:0] rsp_e;
    cmd_t          head, c;
    if (HRESET) begin
      model_reset();
      return;
    end
    iss      = m_issue();
    acc_addr = iss && i_HREADY;
    push_rsp = m_d_vld && i_HREADY;
    pop_rsp  = (exp_q.size() != 0) && rsp_ready;
    acc_cmd  = cmd_valid && (m_cmd_q.size() < CD);
    rsp_e    = {m_d_write, (i_HRESP == 2'b01), (m_d_write ? {DW{1'b0}} : i_HRDATA)};
    if (pop_rsp)  void'(exp_q.pop_front());
    if (push_rsp) exp_q.push_back(rsp_e);
    if (i_HREADY) m_err = 1'b0;
    else if (m_d_vld && i_HRESP == 2'b01) m_err = 1'b1;
    if (acc_addr) begin
      head      = m_cmd_q.pop_front();
      m_d_vld   = 1'b1;
      m_d_write = head.w;
      m_d_wdata = head.d;
    end else if (i_HREADY) begin
      m_d_vld = 1'b0;
    end
    if (acc_cmd) begin
      c.w = cmd_write;
      c.a = cmd_addr;
      c.d = cmd_wdata;
      m_cmd_q.push_back(c);
    end
    last_cmd_acc = acc_cmd;
  endtask

  // One cycle: compare on the falling edge, update model on the rising edge.
  task automatic step();
    @(negedge HCLK);
    compare_outputs();
    @(posedge HCLK);
    model_update();
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_cmd(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
  endtask

  task automatic set_slave(input logic rdy, input logic [1:0] resp, input logic [DW-1:0] rd);
    i_HREADY = rdy;
    i_HRESP  = resp;
    i_HRDATA = rd;
  endtask

  task automatic drain(input int n);
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      set_slave(1'b1, 2'b00, '0);
      step();
    end
  endtask

  task automatic drive_cmd_random();
    if (!(cmd_valid && !last_cmd_acc)) begin
      cmd_valid = ($urandom_range(0, 9) < 6);
      cmd_write = 1'($urandom_range(0, 1));
      cmd_addr  = $urandom & 32'hFFFF_FFFC;
      cmd_wdata = $urandom;
    end
  endtask

  // Slave obeys AHB: ERROR is HREADY=0 then HREADY=1, both with HRESP=ERROR.
  task automatic drive_slave_random();
    int r;
    i_HRDATA = $urandom;
    if (slv_err2) begin
      i_HREADY = 1'b1;
      i_HRESP  = 2'b01;
      slv_err2 = 1'b0;
    end else if (m_d_vld) begin
      r = $urandom_range(0, 9);
      i_HRESP  = 2'b00;
      i_HREADY = (r < 6);
      if (r >= 8) begin
        i_HRESP  = 2'b01;
        slv_err2 = 1'b1;
      end
    end else begin
      i_HREADY = ($urandom_range(0, 9) != 0);
      i_HRESP  = 2'b00;
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int nonseq, sent, pops;
    HRESET    = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    rsp_ready = 1'b0;
    set_slave(1'b1, 2'b00, '0);
    model_reset();

    // reset state
    for (int i = 0; i < 3; i++) step();
    check("rst_htrans", 64'(o_HTRANS), 64'd0);
    check("rst_haddr", 64'(o_HADDR), 64'd0);
    check("rst_hwrite", 64'(o_HWRITE), 64'd0);
    check("rst_hwdata", 64'(o_HWDATA), 64'd0);
    check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    HRESET = 1'b0;
    step();

    // single write
    rsp_ready = 1'b1;
    set_cmd(1'b1, 32'h0000_1000, 32'hDEAD_BEEF);
    step();
    cmd_valid = 1'b0;
    check("wr_htrans", 64'(o_HTRANS), 64'd2);
    check("wr_haddr", 64'(o_HADDR), 64'h1000);
    check("wr_hwrite", 64'(o_HWRITE), 64'd1);
    step();
    check("wr_hwdata", 64'(o_HWDATA), 64'hDEAD_BEEF);
    check("wr_idle", 64'(o_HTRANS), 64'd0);
    check("wr_rsp_early", 64'(rsp_valid), 64'd0);
    step();
    check("wr_rsp_valid", 64'(rsp_valid), 64'd1);
    check("wr_rsp_write", 64'(rsp_write), 64'd1);
    check("wr_rsp_err", 64'(rsp_err), 64'd0);
    check("wr_rsp_rdata", 64'(rsp_rdata), 64'd0);
    step();
    check("wr_done_busy", 64'(busy), 64'd0);
    drain(3);

    // pipelined reads
    for (int s = 0; s < 7; s++) begin
      if (s < 4) set_cmd(1'b0, 32'h1000 + 32'(4 * s), '0);
      else cmd_valid = 1'b0;
      set_slave(1'b1, 2'b00, (s >= 2 && s <= 5) ? 32'(32'h11 * (s - 1)) : 32'h0);
      step();
      if (s < 4) begin
        check("pipe_htrans", 64'(o_HTRANS), 64'd2);
        check("pipe_haddr", 64'(o_HADDR), 64'(32'h1000 + 32'(4 * s)));
      end else begin
        check("pipe_idle", 64'(o_HTRANS), 64'd0);
      end
      if (s >= 2 && s <= 5) begin
        check("pipe_rsp_valid", 64'(rsp_valid), 64'd1);
        check("pipe_rsp_write", 64'(rsp_write), 64'd0);
        check("pipe_rsp_rdata", 64'(rsp_rdata), 64'(32'h11 * (s - 1)));
      end
      if (s == 6) check("pipe_rsp_empty", 64'(rsp_valid), 64'd0);
    end
    drain(3);

    // wait states on the first of two writes
    set_cmd(1'b1, 32'h3000, 32'hAAAA_0001);
    set_slave(1'b1, 2'b00, '0);
    step();
    set_cmd(1'b1, 32'h3004, 32'hBBBB_0002);
    step();
    cmd_valid = 1'b0;
    for (int s = 0; s < 3; s++) begin
      check("ws_htrans", 64'(o_HTRANS), 64'd2);
      check("ws_haddr", 64'(o_HADDR), 64'h3004);
      check("ws_hwdata", 64'(o_HWDATA), 64'hAAAA_0001);
      set_slave((s == 2), 2'b00, '0);
      step();
    end
    check("ws_hwdata2", 64'(o_HWDATA), 64'hBBBB_0002);
    check("ws_idle", 64'(o_HTRANS), 64'd0);
    check("ws_rsp0_valid", 64'(rsp_valid), 64'd1);
    check("ws_rsp0_err", 64'(rsp_err), 64'd0);
    step();
    check("ws_rsp1_valid", 64'(rsp_valid), 64'd1);
    check("ws_rsp1_write", 64'(rsp_write), 64'd1);
    check("ws_rsp1_err", 64'(rsp_err), 64'd0);
    drain(3);

    // two-cycle ERROR with a pending write behind it
    set_cmd(1'b0, 32'h2000, '0);
    set_slave(1'b1, 2'b00, '0);
    step();
    check("err_haddr_rd", 64'(o_HADDR), 64'h2000);
    set_cmd(1'b1, 32'h2004, 32'hC0DE_0001);
    step();
    check("err_haddr_wr", 64'(o_HADDR), 64'h2004);
    cmd_valid = 1'b0;
    set_slave(1'b0, 2'b01, '0);
    step();
    check("err_cycle2_idle", 64'(o_HTRANS), 64'd0);
    check("err_cycle2_busy", 64'(busy), 64'd1);
    set_slave(1'b1, 2'b01, 32'h5555);
    step();
    check("err_reissue_htrans", 64'(o_HTRANS), 64'd2);
    check("err_reissue_haddr", 64'(o_HADDR), 64'h2004);
    check("err_rsp_valid", 64'(rsp_valid), 64'd1);
    check("err_rsp_err", 64'(rsp_err), 64'd1);
    check("err_rsp_rdata", 64'(rsp_rdata), 64'h5555);
    set_slave(1'b1, 2'b00, '0);
    step();
    check("err_wr_hwdata", 64'(o_HWDATA), 64'hC0DE_0001);
    step();
    check("err_rsp2_valid", 64'(rsp_valid), 64'd1);
    check("err_rsp2_write", 64'(rsp_write), 64'd1);
    check("err_rsp2_err", 64'(rsp_err), 64'd0);
    drain(3);

    // response backpressure: credits allow exactly RD transfers
    rsp_ready = 1'b0;
    sent      = 0;
    nonseq    = 0;
    for (int s = 0; s < 16; s++) begin
      if (sent < 6) set_cmd(1'b0, 32'h4000 + 32'(4 * sent), '0);
      else cmd_valid = 1'b0;
      set_slave(1'b1, 2'b00, $urandom);
      step();
      if (last_cmd_acc) sent++;
      if (o_HTRANS == 2'b10) nonseq++;
    end
    check("bp_nonseq", 64'(nonseq), 64'd4);
    check("bp_idle", 64'(o_HTRANS), 64'd0);
    check("bp_rsp_valid", 64'(rsp_valid), 64'd1);
    rsp_ready = 1'b1;
    nonseq    = 0;
    pops      = 0;
    for (int s = 0; s < 16; s++) begin
      if (rsp_valid && rsp_ready) pops++;
      if (o_HTRANS == 2'b10) nonseq++;
      set_slave(1'b1, 2'b00, $urandom);
      step();
    end
    check("bp_resume_nonseq", 64'(nonseq), 64'd2);
    check("bp_pops", 64'(pops), 64'd6);
    check("bp_busy", 64'(busy), 64'd0);

    // reset during a wait-stated data phase
    set_cmd(1'b1, 32'h5000, 32'h0000_CAFE);
    set_slave(1'b1, 2'b00, 32'h77);
    step();
    cmd_valid = 1'b0;
    step();
    set_slave(1'b0, 2'b00, 32'h77);
    step();
    HRESET = 1'b1;
    model_reset();
    #1;
    check("mrst_htrans", 64'(o_HTRANS), 64'd0);
    check("mrst_cmd_ready", 64'(cmd_ready), 64'd1);
    check("mrst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("mrst_busy", 64'(busy), 64'd0);
    check("mrst_hwdata", 64'(o_HWDATA), 64'd0);
    step();
    step();
    HRESET = 1'b0;
    set_slave(1'b1, 2'b00, 32'h77);
    set_cmd(1'b0, 32'h5004, '0);
    step();
    cmd_valid = 1'b0;
    check("post_rst_haddr", 64'(o_HADDR), 64'h5004);
    step();
    step();
    check("post_rst_rsp_valid", 64'(rsp_valid), 64'd1);
    check("post_rst_rsp_write", 64'(rsp_write), 64'd0);
    check("post_rst_rsp_rdata", 64'(rsp_rdata), 64'h77);
    drain(3);

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      drive_cmd_random();
      drive_slave_random();
      rsp_ready = ($urandom_range(0, 9) < 7);
      step();
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      drive_slave_random();
      step();
    end
    check("final_busy", 64'(busy), 64'd0);
    check("final_rsp_valid", 64'(rsp_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
